jk_counter_using_dff: RTL and testbench

JK_COUNTER_USING_DFF -- requirements
Module: jk_counter_using_dff

---
 rtl/jk_counter_pkg.sv | 11 +
 rtl/jk_counter_using_dff_if.sv | 15 +
 rtl/jkff_using_dff.sv | 24 ++
 rtl/jk_counter_using_dff.sv | 43 ++++
 tb/tb_jk_counter_using_dff.sv | 112 +++++++++++
 5 files changed

// File: rtl/jk_counter_pkg.sv
// jk_counter_pkg: default counter geometry and JK excitation encodings
package jk_counter_pkg;
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 10;
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_op_e;
endpackage

// File: rtl/jk_counter_using_dff_if.sv
// jk_counter_using_dff_if: control inputs and count outputs of the modulo counter
interface jk_counter_using_dff_if
   import jk_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   modport master (output en, up, load, load_val, input q, tc);
   modport slave  (input en, up, load, load_val, output q, tc);
endinterface

// File: rtl/jkff_using_dff.sv
// jkff_using_dff: single-bit JK flip-flop built from a D flip-flop
module jkff_using_dff
   import jk_counter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);
   jk_op_e op;
   logic   d;
   assign op = jk_op_e'({j, k});
   // characteristic equation D = J&~Q | ~K&Q, spelled out per excitation code
   always_comb begin
      d = (op == JK_HOLD) ? q :
          (op == JK_RST)  ? 1'b0 :
          (op == JK_SET)  ? 1'b1 : ~q;
   end
   // the D storage element, cleared synchronously
   always_ff @(posedge clk) begin
      q <= reset ? 1'b0 : d;
   end
endmodule

// File: rtl/jk_counter_using_dff.sv
// jk_counter_using_dff: up/down modulo counter with load, stored in JK cells
module jk_counter_using_dff
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
)(
   input logic                   clk,
   input logic                   reset,
   jk_counter_using_dff_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             at_max;
   logic             at_zero;
   logic             lv_ok;
   // desired next count, minimal JK excitation and terminal-count flag
   always_comb begin
      at_max  = (q == MAX);
      at_zero = (q == '0);
      lv_ok   = ({1'b0, bus.load_val} < MOD_EXT);
      nxt     = bus.load ? (lv_ok ? bus.load_val : MAX) :
                bus.en   ? (bus.up ? (at_max ? '0 : q + WIDTH'(1))
                                   : (at_zero ? MAX : q - WIDTH'(1))) : q;
      j       = ~q & nxt;
      k       = q & ~nxt;
      bus.tc  = ~reset & bus.en & ~bus.load & (bus.up ? at_max : at_zero);
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jkff_using_dff u_ff (
         .clk   (clk),
         .reset (reset),
         .j     (j[i]),
         .k     (k[i]),
         .q     (q[i])
      );
   end
   assign bus.q = q;
endmodule

// File: tb/tb_jk_counter_using_dff.sv
// tb_jk_counter_using_dff: directed vector check of the JK modulo-10 counter
module tb_jk_counter_using_dff;
   import jk_counter_pkg::*;
   typedef struct {
      logic       r;
      logic       l;
      logic       e;
      logic       u;
      logic [3:0] lv;
      logic [3:0] eq;
      logic       etc;
      logic       jk;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   logic f_reset;
   logic f_j;
   logic f_k;
   logic f_q;
   int   checks = 0;
   int   fails  = 0;
   vec_t vecs[$];
   always #5 clk = ~clk;
   jk_counter_using_dff_if #(.WIDTH(4)) bus ();
   jk_counter_using_dff #(.WIDTH(4), .MODULUS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   jkff_using_dff ff (
      .clk   (clk),
      .reset (f_reset),
      .j     (f_j),
      .k     (f_k),
      .q     (f_q)
   );
   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask
   task automatic add(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] lv, input logic [3:0] eq, input logic etc, input logic jk);
      vecs.push_back('{r, l, e, u, lv, eq, etc, jk});
   endtask
   task automatic ff_step(input logic r, input logic j, input logic k);
      @(negedge clk);
      f_reset = r;
      f_j     = j;
      f_k     = k;
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1;
      bus.en = 1'b0;
      bus.up = 1'b0;
      bus.load = 1'b0;
      bus.load_val = '0;
      f_reset = 1'b1;
      f_j = 1'b0;
      f_k = 1'b0;
      add(1, 1, 1, 0, 5, 0, 0, 0);
      for (int n = 0; n < 12; n++) add(0, 0, 1, 1, 0, 4'((n + 1) % 10), (n % 10) == 9, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 9, 1, 0);
      add(0, 0, 1, 0, 0, 8, 0, 0);
      add(0, 0, 1, 0, 0, 7, 0, 0);
      add(0, 1, 1, 1, 6, 6, 0, 0);
      add(0, 1, 1, 1, 13, 9, 0, 0);
      add(0, 1, 1, 1, 15, 9, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4, 4, 0, 0);
      for (int n = 0; n < 5; n++) add(0, 0, 0, n[0], 9, 4, 0, 1);
      add(0, 0, 1, 1, 0, 5, 0, 0);
      add(0, 0, 1, 0, 0, 4, 0, 0);
      add(0, 0, 1, 1, 0, 5, 0, 0);
      add(0, 0, 1, 1, 0, 6, 0, 0);
      add(0, 0, 1, 1, 0, 7, 0, 0);
      add(1, 1, 1, 1, 3, 0, 0, 0);
      add(0, 0, 1, 1, 0, 1, 0, 0);
      foreach (vecs[i]) begin
         @(negedge clk);
         reset        = vecs[i].r;
         bus.load     = vecs[i].l;
         bus.en       = vecs[i].e;
         bus.up       = vecs[i].u;
         bus.load_val = vecs[i].lv;
         #1;
         check("tc", i, 16'(bus.tc), 16'(vecs[i].etc));
         if (vecs[i].jk) check("jk_idle", i, 16'({dut.j, dut.k}), 16'd0);
         @(posedge clk);
         #1;
         check("q", i, 16'(bus.q), 16'(vecs[i].eq));
      end
      ff_step(1, 0, 0);
      check("ff_reset", 0, 16'(f_q), 16'd0);
      for (int c = 0; c < 4; c++) begin
         ff_step(0, 1, 0);
         check("ff_pre", c, 16'(f_q), 16'd1);
         ff_step(0, c[1], c[0]);
         check("ff_jk", c, 16'(f_q), 16'(c == 0 || c == 2));
      end
      ff_step(0, 1, 0);
      ff_step(1, 1, 0);
      check("ff_reset", 1, 16'(f_q), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
